// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared definitions for the Wishbone decode/mux block: FSM state
//            encoding, the user-area base address and the fixed data values
//            returned for timed-out and unmapped transactions.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    localparam logic [31:0] WB_USER_BASE     = 32'h3000_0000;
    localparam logic [31:0] WB_TIMEOUT_DATA  = 32'hFFFF_FFFF;
    localparam logic [31:0] WB_UNMAPPED_DATA = 32'h0000_0000;

    // The decode window always spans 16 slots, independent of how many are mapped
    localparam int unsigned WB_WINDOW_SLOTS  = 16;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_watchdog
// Purpose  : Up-counter with synchronous clear and a terminal-count flag.
//            Counts while enabled and holds once the terminal value is hit.
// Ports    : clk_i    - clock
//            rst_ni   - asynchronous active-low reset
//            clear_i  - reload the counter with zero
//            en_i     - count enable
//            tc_o     - counter has reached TERMINAL
// Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int unsigned TERMINAL = 15,
    parameter int unsigned WIDTH    = $clog2(TERMINAL + 1) + 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign tc_o = (cnt_q >= TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/wishbone_decode_mux.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_decode_mux
// Purpose  : Wishbone classic decoder / response mux from the management-core
//            user-area port to NUM_SLAVES single-word register slaves. One
//            transaction in flight; a watchdog completes slave cycles that
//            never acknowledge.
// Ports    : wb_clk_i / wb_rst_n_i           - clock, async active-low reset
//            wbs_cyc/stb/we/adr/dat_i        - master request
//            wbs_ack_o / wbs_dat_o           - registered single-cycle response
//            s_cyc_o, s_we_o, s_stb_o        - slave control (one-hot strobe)
//            s_adr_o, s_dat_o                - latched address / write data
//            s_ack_i, s_dat_i                - slave acks and packed read data
//            timeout_cnt_o                   - saturating watchdog-event count
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_decode_mux
    import wb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = WB_USER_BASE,
    parameter logic [31:0] STRIDE     = 32'h4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    output logic [7:0]               timeout_cnt_o
);

    wb_state_e             state_q;
    logic [3:0]            idx_q;
    logic [NUM_SLAVES-1:0] ack_q;

    logic [31:0]           w_offset;
    logic                  w_hit;
    logic [3:0]            w_idx;
    logic                  w_mapped;
    logic                  w_accept;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_qual_ack;
    logic [31:0]           w_sel_dat;
    logic                  w_wdog_tc;

    // A hit is an exact match on one of the 16 slot addresses; comparing
    // against each slot avoids a general divider for the index and alignment.
    always_comb begin
        w_offset = wbs_adr_i - BASE_ADDR;
        w_hit    = 1'b0;
        w_idx    = '0;
        if (wbs_adr_i >= BASE_ADDR) begin
            for (int k = 0; k < WB_WINDOW_SLOTS; k++) begin
                if (w_offset == 32'(k) * STRIDE) begin
                    w_hit = 1'b1;
                    w_idx = 4'(k);
                end
            end
        end
    end

    assign w_mapped = ({28'd0, w_idx} < 32'(NUM_SLAVES));
    assign w_accept = wbs_cyc_i & wbs_stb_i & w_hit;

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_onehot[k] = (w_idx == 4'(k));
        end
    end

    // Only a rising ack from the selected slave completes the cycle, so a
    // level or sticky ack cannot complete a second transaction.
    always_comb begin
        w_qual_ack = 1'b0;
        w_sel_dat  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == 4'(k)) begin
                w_qual_ack = s_ack_i[k] & ~ack_q[k];
                w_sel_dat  = s_dat_i[32*k +: 32];
            end
        end
    end

    wb_watchdog #(
        .TERMINAL (TIMEOUT)
    ) u_watchdog (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .clear_i ((state_q == ST_IDLE) && w_accept && w_mapped),
        .en_i    (state_q == ST_REQ),
        .tc_o    (w_wdog_tc)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            ack_q         <= '0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            s_cyc_o       <= 1'b0;
            s_we_o        <= 1'b0;
            s_stb_o       <= '0;
            s_adr_o       <= '0;
            s_dat_o       <= '0;
            timeout_cnt_o <= '0;
        end else begin
            ack_q     <= s_ack_i;
            wbs_ack_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        s_adr_o <= wbs_adr_i;
                        s_dat_o <= wbs_dat_i;
                        s_we_o  <= wbs_we_i;
                        idx_q   <= w_idx;
                        if (w_mapped) begin
                            state_q <= ST_REQ;
                            s_cyc_o <= 1'b1;
                            s_stb_o <= w_onehot;
                        end else begin
                            state_q   <= ST_ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= WB_UNMAPPED_DATA;
                        end
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i) begin
                        // Master abandoned the cycle: no response owed
                        state_q <= ST_IDLE;
                        s_cyc_o <= 1'b0;
                        s_stb_o <= '0;
                    end else if (w_qual_ack) begin
                        state_q   <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= w_sel_dat;
                        s_cyc_o   <= 1'b0;
                        s_stb_o   <= '0;
                    end else if (w_wdog_tc) begin
                        state_q   <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= WB_TIMEOUT_DATA;
                        s_cyc_o   <= 1'b0;
                        s_stb_o   <= '0;
                        if (timeout_cnt_o != 8'hFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 8'd1;
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_decode_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_decode_mux
// Purpose  : Self-checking bench for wishbone_decode_mux with behavioural
//            register slaves (pulse, never-ack and sticky-ack behaviours) and
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_decode_mux;

    localparam int          NS      = 4;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          TIMEOUT = 15;
    localparam int          LIMIT   = TIMEOUT + 10;
    localparam int          M_PULSE = 0;
    localparam int          M_NEVER = 1;
    localparam int          M_STICKY = 2;

    logic              clk;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [31:0]       adr, wdat;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              s_cyc_o, s_we_o;
    logic [NS-1:0]     s_stb_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [NS-1:0]     s_ack;
    logic [32*NS-1:0]  s_dat;
    logic [7:0]        timeout_cnt_o;

    logic [31:0] mem      [NS];
    logic [31:0] init_val [NS];
    int          mode     [NS];

    // reference model state
    logic [31:0] ref_mem   [NS];
    logic        sticky_hi [NS];
    int          model_to;

    int tests_run;
    int tests_failed;

    wishbone_decode_mux #(
        .NUM_SLAVES (NS),
        .BASE_ADDR  (BASE),
        .STRIDE     (32'h4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_we_o        (s_we_o),
        .s_stb_o       (s_stb_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_ack_i       (s_ack),
        .s_dat_i       (s_dat),
        .timeout_cnt_o (timeout_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_dat = {mem[3], mem[2], mem[1], mem[0]};

    // Behavioural slaves
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= '0;
            for (int k = 0; k < NS; k++) mem[k] <= init_val[k];
        end else begin
            for (int k = 0; k < NS; k++) begin
                case (mode[k])
                    M_PULSE: begin
                        s_ack[k] <= s_stb_o[k] & ~s_ack[k];
                        if (s_stb_o[k] && s_ack[k] && s_we_o) mem[k] <= s_dat_o;
                    end
                    M_NEVER: s_ack[k] <= 1'b0;
                    default: s_ack[k] <= s_ack[k] | s_stb_o[k];
                endcase
            end
        end
    end

    // Transaction-level model: predicts outcome from address decode rules
    task automatic model_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                             output logic e_ack, output int e_cyc,
                             output logic [31:0] e_dat, output logic [NS-1:0] e_stb);
        logic [31:0] off;
        int idx;
        e_ack = 1'b0; e_cyc = 0; e_dat = '0; e_stb = '0;
        if (a < BASE) return;
        off = a - BASE;
        if (off >= 64 || (off % 4) != 0) return;
        idx = int'(off / 4);
        e_ack = 1'b1;
        if (idx >= NS) begin
            e_cyc = 1;
            e_dat = 32'h0;
            return;
        end
        e_stb = NS'(1) << idx;
        if (mode[idx] == M_PULSE || (mode[idx] == M_STICKY && !sticky_hi[idx])) begin
            e_cyc = 3;
            e_dat = ref_mem[idx];
            if (mode[idx] == M_STICKY) sticky_hi[idx] = 1'b1;
            else if (w) ref_mem[idx] = d;
        end else begin
            e_cyc = TIMEOUT + 2;
            e_dat = 32'hFFFF_FFFF;
            if (model_to < 255) model_to++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            ref_mem[k]   = init_val[k];
            sticky_hi[k] = 1'b0;
        end
        model_to = 0;
    endtask

    // Drives one master transaction and reports what was observed
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic got, output int acyc, output logic [31:0] rd,
                           output logic [NS-1:0] stbs, output logic [31:0] sadr,
                           output logic [31:0] sdat, output logic swe, output logic ack_after);
        int c;
        got = 1'b0; acyc = 0; rd = '0; stbs = '0; sadr = '0; sdat = '0; swe = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d;
        @(posedge clk);
        c = 0;
        while (!got && c < LIMIT) begin
            @(negedge clk);
            c++;
            if (s_stb_o != '0 && stbs == '0) begin
                sadr = s_adr_o; sdat = s_dat_o; swe = s_we_o;
            end
            stbs |= s_stb_o;
            if (wbs_ack_o) begin
                got = 1'b1; acyc = c; rd = wbs_dat_o;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        ack_after = wbs_ack_o;
    endtask

    logic           o_got, o_swe, o_after, e_ack;
    int             o_cyc, e_cyc;
    logic [31:0]    o_rd, o_sadr, o_sdat, e_dat;
    logic [NS-1:0]  o_stb, e_stb;

    task automatic test_reset();
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        for (int k = 0; k < NS; k++) begin
            init_val[k] = $urandom;
            mode[k]     = M_PULSE;
        end
        init_val[3] = 32'h1234_5678;
        mode[2]     = M_NEVER;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if ({wbs_ack_o, s_cyc_o, s_we_o} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 000", {wbs_ack_o, s_cyc_o, s_we_o});
        end
        tests_run++;
        if (s_stb_o !== '0) begin
            tests_failed++; $display("FAIL reset_stb: got %b expected 0", s_stb_o);
        end
        tests_run++;
        if ({wbs_dat_o, s_adr_o, s_dat_o} !== 96'd0) begin
            tests_failed++; $display("FAIL reset_data: got %h %h %h expected 0", wbs_dat_o, s_adr_o, s_dat_o);
        end
        tests_run++;
        if (timeout_cnt_o !== 8'd0) begin
            tests_failed++; $display("FAIL reset_tocnt: got %0d expected 0", timeout_cnt_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_slave1();
        model_txn(32'h3000_0004, 1'b1, 32'hA5A5_0001, e_ack, e_cyc, e_dat, e_stb);
        run_txn(32'h3000_0004, 1'b1, 32'hA5A5_0001, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
        tests_run++;
        if (o_stb !== 4'b0010) begin
            tests_failed++; $display("FAIL wr_stb: got %b expected 0010", o_stb);
        end
        tests_run++;
        if (o_sdat !== 32'hA5A5_0001 || o_sadr !== 32'h3000_0004 || o_swe !== 1'b1) begin
            tests_failed++; $display("FAIL wr_slave_bus: got %h %h %b expected a5a50001 30000004 1", o_sdat, o_sadr, o_swe);
        end
        tests_run++;
        if (o_got !== 1'b1 || o_cyc != 3) begin
            tests_failed++; $display("FAIL wr_ack_cycle: got ack=%b cycle=%0d expected ack=1 cycle=3", o_got, o_cyc);
        end
        tests_run++;
        if (o_after !== 1'b0) begin
            tests_failed++; $display("FAIL wr_ack_width: got ack still %b expected 0", o_after);
        end
    endtask

    task automatic test_read_slave3();
        model_txn(32'h3000_000C, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
        run_txn(32'h3000_000C, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
        tests_run++;
        if (o_got !== 1'b1 || o_rd !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL rd_slave3: got ack=%b data=%h expected ack=1 data=12345678", o_got, o_rd);
        end
        tests_run++;
        if (o_stb !== 4'b1000 || o_cyc != 3) begin
            tests_failed++; $display("FAIL rd_slave3_stb: got stb=%b cycle=%0d expected 1000 3", o_stb, o_cyc);
        end
    endtask

    task automatic test_unmapped();
        model_txn(32'h3000_0020, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
        run_txn(32'h3000_0020, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
        tests_run++;
        if (o_got !== 1'b1 || o_cyc != 1 || o_rd !== 32'h0) begin
            tests_failed++; $display("FAIL unmapped: got ack=%b cycle=%0d data=%h expected 1 1 0", o_got, o_cyc, o_rd);
        end
        tests_run++;
        if (o_stb !== '0 || o_after !== 1'b0) begin
            tests_failed++; $display("FAIL unmapped_stb: got stb=%b after=%b expected 0 0", o_stb, o_after);
        end
    endtask

    task automatic test_miss();
        logic [31:0] addrs [3];
        addrs[0] = 32'h3000_0100; addrs[1] = 32'h2FFF_FFFC; addrs[2] = 32'h3000_0006;
        for (int i = 0; i < 3; i++) begin
            model_txn(addrs[i], 1'b1, 32'hDEAD_BEEF, e_ack, e_cyc, e_dat, e_stb);
            run_txn(addrs[i], 1'b1, 32'hDEAD_BEEF, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
            tests_run++;
            if (o_got !== 1'b0 || o_stb !== '0) begin
                tests_failed++; $display("FAIL miss %h: got ack=%b stb=%b expected 0 0", addrs[i], o_got, o_stb);
            end
        end
    endtask

    task automatic test_timeout();
        tests_run++;
        if (timeout_cnt_o !== 8'd0) begin
            tests_failed++; $display("FAIL to_cnt_before: got %0d expected 0", timeout_cnt_o);
        end
        model_txn(32'h3000_0008, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
        run_txn(32'h3000_0008, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
        tests_run++;
        if (o_got !== 1'b1 || o_cyc != 17 || o_rd !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL timeout: got ack=%b cycle=%0d data=%h expected 1 17 ffffffff", o_got, o_cyc, o_rd);
        end
        tests_run++;
        if (timeout_cnt_o !== 8'd1) begin
            tests_failed++; $display("FAIL to_cnt_after: got %0d expected 1", timeout_cnt_o);
        end
    endtask

    task automatic test_sticky();
        mode[0] = M_STICKY;
        for (int i = 0; i < 2; i++) begin
            model_txn(32'h3000_0000, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
            run_txn(32'h3000_0000, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
            tests_run++;
            if (o_got !== 1'b1 || o_cyc != e_cyc || o_rd !== e_dat) begin
                tests_failed++; $display("FAIL sticky_txn%0d: got cycle=%0d data=%h expected %0d %h", i, o_cyc, o_rd, e_cyc, e_dat);
            end
            tests_run++;
            if (timeout_cnt_o !== 8'(model_to)) begin
                tests_failed++; $display("FAIL sticky_cnt%0d: got %0d expected %0d", i, timeout_cnt_o, model_to);
            end
        end
        mode[0] = M_PULSE;
        sticky_hi[0] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_abort();
        int seen_ack;
        seen_ack = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0008; we = 1'b0;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (s_cyc_o !== 1'b1 || s_stb_o !== 4'b0100) begin
            tests_failed++; $display("FAIL abort_req: got cyc=%b stb=%b expected 1 0100", s_cyc_o, s_stb_o);
        end
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (wbs_ack_o) seen_ack++;
        end
        tests_run++;
        if (seen_ack != 0 || s_cyc_o !== 1'b0 || s_stb_o !== '0) begin
            tests_failed++; $display("FAIL abort_idle: got acks=%0d cyc=%b stb=%b expected 0 0 0", seen_ack, s_cyc_o, s_stb_o);
        end
        tests_run++;
        if (timeout_cnt_o !== 8'(model_to)) begin
            tests_failed++; $display("FAIL abort_cnt: got %0d expected %0d", timeout_cnt_o, model_to);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic w;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 3));
                3:       a = BASE + 32'(4 * $urandom_range(4, 15));
                4:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                default: a = ($urandom_range(0, 1) == 1) ? BASE + 32'd64 + 32'(4 * $urandom_range(0, 1000))
                                                         : BASE - 32'(4 * $urandom_range(1, 1000));
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            model_txn(a, w, d, e_ack, e_cyc, e_dat, e_stb);
            run_txn(a, w, d, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
            tests_run++;
            if (o_got !== e_ack || o_stb !== e_stb) begin
                tests_failed++; $display("FAIL rand%0d %h: got ack=%b stb=%b expected %b %b", i, a, o_got, o_stb, e_ack, e_stb);
            end
            if (e_ack) begin
                tests_run++;
                if (o_cyc != e_cyc || o_rd !== e_dat || o_after !== 1'b0) begin
                    tests_failed++; $display("FAIL rand%0d_resp %h: got cycle=%0d data=%h after=%b expected %0d %h 0", i, a, o_cyc, o_rd, o_after, e_cyc, e_dat);
                end
            end
            if (e_stb != '0) begin
                tests_run++;
                if (o_sadr !== a || o_swe !== w || (w && o_sdat !== d)) begin
                    tests_failed++; $display("FAIL rand%0d_bus: got adr=%h we=%b dat=%h expected %h %b %h", i, o_sadr, o_swe, o_sdat, a, w, d);
                end
            end
            tests_run++;
            if (timeout_cnt_o !== 8'(model_to)) begin
                tests_failed++; $display("FAIL rand%0d_cnt: got %0d expected %0d", i, timeout_cnt_o, model_to);
            end
        end
    endtask

    task automatic test_saturation();
        int extra;
        extra = 0;
        while (extra < 3) begin
            if (model_to == 255) extra++;
            model_txn(32'h3000_0008, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
            run_txn(32'h3000_0008, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
            tests_run++;
            if (timeout_cnt_o !== 8'(model_to) || o_cyc != TIMEOUT + 2) begin
                tests_failed++; $display("FAIL sat_cnt: got cnt=%0d cycle=%0d expected %0d %0d", timeout_cnt_o, o_cyc, model_to, TIMEOUT + 2);
            end
        end
        tests_run++;
        if (timeout_cnt_o !== 8'd255) begin
            tests_failed++; $display("FAIL sat_hold: got %0d expected 255", timeout_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0008; we = 1'b1; wdat = 32'h5555_AAAA;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (s_stb_o !== 4'b0100 || s_cyc_o !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_req: got stb=%b cyc=%b expected 0100 1", s_stb_o, s_cyc_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({wbs_ack_o, s_cyc_o, s_we_o, s_stb_o} !== 7'd0 || timeout_cnt_o !== 8'd0
            || {wbs_dat_o, s_adr_o, s_dat_o} !== 96'd0) begin
            tests_failed++; $display("FAIL rstmid_async: got ack=%b cyc=%b we=%b stb=%b cnt=%0d adr=%h expected all 0",
                                     wbs_ack_o, s_cyc_o, s_we_o, s_stb_o, timeout_cnt_o, s_adr_o);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        model_txn(32'h3000_0004, 1'b0, 32'h0, e_ack, e_cyc, e_dat, e_stb);
        run_txn(32'h3000_0004, 1'b0, 32'h0, o_got, o_cyc, o_rd, o_stb, o_sadr, o_sdat, o_swe, o_after);
        tests_run++;
        if (o_got !== 1'b1 || o_cyc != 3 || o_rd !== e_dat || timeout_cnt_o !== 8'd0) begin
            tests_failed++; $display("FAIL rstmid_after: got ack=%b cycle=%0d data=%h cnt=%0d expected 1 3 %h 0", o_got, o_cyc, o_rd, timeout_cnt_o, e_dat);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_write_slave1();
        test_read_slave3();
        test_unmapped();
        test_miss();
        test_timeout();
        test_sticky();
        test_abort();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
